// File: rtl/race_ctrl.sv
// Frame-rate sequencer for one drag-racing lane: start lights, false-start detect, speed/position.
// Optional RACE_TIMER_EN macro enables the race_time frame counter.
module race_ctrl #(
  parameter int X_START   = 256,
  parameter int X_FINISH  = 900,
  parameter int Y_POS     = 400,
  parameter int CD_FRAMES = 60,
  parameter int ACC_DIV   = 4,
  parameter int V_MAX     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        key_start,
  input  logic        key_gas,
  output logic [10:0] car_xpos,
  output logic [10:0] car_ypos,
  output logic        car_mov,
  output logic [1:0]  light,
  output logic [1:0]  state,
  output logic        false_start,
  output logic [15:0] race_time
);
  localparam int CNT_W = $clog2(CD_FRAMES + 1);
  localparam int ACC_W = $clog2(ACC_DIV + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CD = 2'd1, RACE = 2'd2, FIN = 2'd3} st_t;

  st_t              st_q, st_n;
  logic             vsync_q, tick;
  logic [1:0]       light_q, light_n;
  logic [10:0]      xpos_q, xpos_n;
  logic [3:0]       speed_q, speed_n, speed_upd;
  logic             mov_q, mov_n, fs_q, fs_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [ACC_W-1:0] acc_q, acc_n;
  logic [11:0]      pos_sum;
  logic             cnt_last, acc_wrap, finish_hit;

  assign tick       = vsync_in & ~vsync_q;
  assign cnt_last   = (cnt_q == CNT_W'(CD_FRAMES - 1));
  assign acc_wrap   = (acc_q == ACC_W'(ACC_DIV - 1));
  // 12-bit sum so a car near the top of the 11-bit range cannot wrap past the line
  assign pos_sum    = {1'b0, xpos_q} + {8'b0, speed_q};
  assign finish_hit = (pos_sum >= 12'(X_FINISH));

  always_comb begin
    speed_upd = speed_q;
    if (acc_wrap) begin
      if (key_gas) speed_upd = (speed_q == 4'(V_MAX)) ? speed_q : speed_q + 4'd1;
      else         speed_upd = (speed_q == 4'd0)     ? speed_q : speed_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_n;
  end

  always_comb begin
    st_n = st_q;
    if (tick) begin
      case (st_q)
        IDLE: if (key_start) st_n = CD;
        CD: begin
          if (key_gas)                           st_n = FIN;
          else if (cnt_last && light_q == 2'd2) st_n = RACE;
        end
        RACE: if (finish_hit) st_n = FIN;
        FIN:  if (key_start)  st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  always_comb begin
    light_n = light_q;
    xpos_n  = xpos_q;
    speed_n = speed_q;
    mov_n   = mov_q;
    fs_n    = fs_q;
    cnt_n   = cnt_q;
    acc_n   = acc_q;
    if (tick) begin
      case (st_q)
        IDLE: if (key_start) begin
          light_n = 2'd1;
          cnt_n   = '0;
        end
        CD: begin
          // false start wins over a light advance on the same tick
          if (key_gas) begin
            light_n = 2'd0;
            fs_n    = 1'b1;
          end else if (cnt_last) begin
            cnt_n   = '0;
            light_n = light_q + 2'd1;
            if (light_q == 2'd2) acc_n = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        RACE: begin
          acc_n = acc_wrap ? '0 : acc_q + ACC_W'(1);
          if (finish_hit) begin
            xpos_n  = 11'(X_FINISH);
            speed_n = 4'd0;
            mov_n   = 1'b0;
          end else begin
            xpos_n  = pos_sum[10:0];
            speed_n = speed_upd;
            mov_n   = (speed_upd != 4'd0);
          end
        end
        FIN: begin
          mov_n = 1'b0;
          if (key_start) begin
            light_n = 2'd0;
            xpos_n  = 11'(X_START);
            speed_n = 4'd0;
            fs_n    = 1'b0;
            cnt_n   = '0;
            acc_n   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      light_q <= 2'd0;
      xpos_q  <= 11'(X_START);
      speed_q <= 4'd0;
      mov_q   <= 1'b0;
      fs_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      vsync_q <= vsync_in;
      light_q <= light_n;
      xpos_q  <= xpos_n;
      speed_q <= speed_n;
      mov_q   <= mov_n;
      fs_q    <= fs_n;
      cnt_q   <= cnt_n;
      acc_q   <= acc_n;
    end
  end

`ifdef RACE_TIMER_EN
  logic [15:0] rt_q;
  always_ff @(posedge clk) begin
    if (rst) rt_q <= 16'h0000;
    else if (tick) begin
      if (st_q == RACE) begin
        if (rt_q != 16'hFFFF) rt_q <= rt_q + 16'd1;
      end else if (st_q == IDLE || st_n == IDLE) begin
        rt_q <= 16'h0000;
      end
    end
  end
  assign race_time = rt_q;
`else
  assign race_time = 16'h0000;
`endif

  assign car_xpos    = xpos_q;
  assign car_ypos    = 11'(Y_POS);
  assign car_mov     = mov_q;
  assign light       = light_q;
  assign state       = st_q;
  assign false_start = fs_q;
endmodule

// File: tb/tb_race_ctrl.sv
// Directed, table-driven bench for race_ctrl with short countdown and fast acceleration.
module tb_race_ctrl;
  logic        clk = 1'b0, rst = 1'b0, vsync_in = 1'b0, key_start = 1'b0, key_gas = 1'b0;
  logic [10:0] car_xpos, car_ypos;
  logic        car_mov, false_start;
  logic [1:0]  light, state;
  logic [15:0] race_time;

`ifdef RACE_TIMER_EN
  localparam bit RT_EN = 1'b1;
`else
  localparam bit RT_EN = 1'b0;
`endif

  int n_chk = 0, n_fail = 0;

  race_ctrl #(.X_START(256), .X_FINISH(270), .Y_POS(400), .CD_FRAMES(4), .ACC_DIV(1), .V_MAX(15)) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .key_start(key_start), .key_gas(key_gas),
    .car_xpos(car_xpos), .car_ypos(car_ypos), .car_mov(car_mov), .light(light),
    .state(state), .false_start(false_start), .race_time(race_time)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, gas;
    logic [1:0]  st, lt;
    logic [10:0] x;
    logic        mov, fs;
    logic [15:0] rt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one short vsync pulse; returns at a negedge after the tick edge has updated outputs
  task automatic frame();
    @(negedge clk) vsync_in = 1'b1;
    @(negedge clk) vsync_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [1:0] lt,
                         input logic [10:0] x, input logic mov, input logic fs, input logic [15:0] rt);
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".light"}, 16'(light), 16'(lt));
    chk({tag, ".xpos"}, 16'(car_xpos), 16'(x));
    chk({tag, ".mov"}, 16'(car_mov), 16'(mov));
    chk({tag, ".fs"}, 16'(false_start), 16'(fs));
    chk({tag, ".rt"}, race_time, RT_EN ? rt : 16'd0);
  endtask

  initial begin
    //           start gas  st  lt  x    mov fs  rt
    vecs[0]  = '{1'b1, 1'b0, 1, 1, 256, 0, 0, 0};  // T: lights on
    vecs[1]  = '{1'b0, 1'b0, 1, 1, 256, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1, 1, 256, 0, 0, 0};  // start ignored in countdown
    vecs[3]  = '{1'b0, 1'b0, 1, 1, 256, 0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1, 2, 256, 0, 0, 0};  // T+4 yellow
    vecs[5]  = '{1'b0, 1'b0, 1, 2, 256, 0, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1, 2, 256, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1, 2, 256, 0, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 2, 3, 256, 0, 0, 0};  // T+8 green, RACE
    vecs[9]  = '{1'b0, 1'b1, 2, 3, 256, 1, 0, 1};
    vecs[10] = '{1'b0, 1'b1, 2, 3, 257, 1, 0, 2};
    vecs[11] = '{1'b0, 1'b1, 2, 3, 259, 1, 0, 3};
    vecs[12] = '{1'b0, 1'b1, 2, 3, 262, 1, 0, 4};
    vecs[13] = '{1'b0, 1'b1, 2, 3, 266, 1, 0, 5};
    vecs[14] = '{1'b0, 1'b1, 3, 3, 270, 0, 0, 6};  // 266+5 crosses 270: clamp
    vecs[15] = '{1'b0, 1'b1, 3, 3, 270, 0, 0, 6};  // FINISH holds
    vecs[16] = '{1'b1, 1'b0, 0, 0, 256, 0, 0, 0};  // restart to IDLE

    do_reset();
    chk_all("reset", 2'd0, 2'd0, 11'd256, 1'b0, 1'b0, 16'd0);
    chk("reset.ypos", 16'(car_ypos), 16'd400);

    // no vsync edge: held keys must not move the FSM
    key_start = 1'b1; key_gas = 1'b1;
    repeat (6) @(negedge clk);
    chk("notick.state", 16'(state), 16'd0);
    key_start = 1'b0; key_gas = 1'b0;

    for (int i = 0; i < 17; i++) begin
      key_start = vecs[i].start;
      key_gas   = vecs[i].gas;
      frame();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].lt, vecs[i].x,
              vecs[i].mov, vecs[i].fs, vecs[i].rt);
    end
    key_start = 1'b0; key_gas = 1'b0;

    // false start on T+2
    key_start = 1'b1; frame(); key_start = 1'b0;
    frame();
    key_gas = 1'b1; frame();
    chk_all("fstart", 2'd3, 2'd0, 11'd256, 1'b0, 1'b1, 16'd0);
    frame();
    chk("fstart.hold", 16'(false_start), 16'd1);
    key_gas = 1'b0; key_start = 1'b1; frame(); key_start = 1'b0;
    chk_all("fstart.clr", 2'd0, 2'd0, 11'd256, 1'b0, 1'b0, 16'd0);

    // accelerate two frames, then coast down, then reset mid-race
    key_start = 1'b1; frame(); key_start = 1'b0;
    repeat (8) frame();
    chk("race2.state", 16'(state), 16'd2);
    key_gas = 1'b1;
    frame(); frame();
    chk_all("accel", 2'd2, 2'd3, 11'd257, 1'b1, 1'b0, 16'd2);
    key_gas = 1'b0;
    frame();
    chk_all("coast1", 2'd2, 2'd3, 11'd259, 1'b1, 1'b0, 16'd3);
    frame();
    chk_all("coast2", 2'd2, 2'd3, 11'd260, 1'b0, 1'b0, 16'd4);
    frame();
    chk_all("coast3", 2'd2, 2'd3, 11'd260, 1'b0, 1'b0, 16'd5);
    do_reset();
    chk_all("midrst", 2'd0, 2'd0, 11'd256, 1'b0, 1'b0, 16'd0);
    chk("midrst.ypos", 16'(car_ypos), 16'd400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
